ain_conditioner: RTL and testbench



---
 rtl/ain_cond_pkg.sv | 17 +
 rtl/ain_conditioner_if.sv | 14 +
 rtl/ain_conditioner_sync2.sv | 28 ++
 rtl/ain_conditioner.sv | 85 ++++++++
 tb/tb_ain_conditioner.sv | 109 ++++++++++
 5 files changed

// File: rtl/ain_cond_pkg.sv
// ain_cond_pkg: types and constants shared between ain_conditioner and the
// downstream pattern-detector FSM.
//   state_t        : debounce FSM state encoding
//   CODE_*         : 2-bit command codes presented on ain
package ain_cond_pkg;

  typedef enum logic {
    STABLE    = 1'b0,
    CANDIDATE = 1'b1
  } state_t;

  localparam logic [1:0] CODE_IDLE = 2'b00;
  localparam logic [1:0] CODE_CLR  = 2'b01;
  localparam logic [1:0] CODE_TGL  = 2'b10;
  localparam logic [1:0] CODE_SET  = 2'b11;

endpackage

// File: rtl/ain_conditioner_if.sv
// ain_conditioner_if: raw switch lines in, debounced code and strobe out.
//   ain_raw    : raw 2-bit switch lines (asynchronous to clk)
//   ain_out    : debounced, registered code
//   ain_strobe : one-cycle pulse when ain_out takes a new value
// Modports: master = the side driving the switches and consuming the code,
//           slave  = the conditioner itself.
interface ain_conditioner_if;
  logic [1:0] ain_raw;
  logic [1:0] ain_out;
  logic       ain_strobe;

  modport master (output ain_raw, input  ain_out, input  ain_strobe);
  modport slave  (input  ain_raw, output ain_out, output ain_strobe);
endinterface

// File: rtl/ain_conditioner_sync2.sv
// sync2: parameterised-width two-flop synchronizer, async active-low reset.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset (clears both stages)
//   i_d     : asynchronous input
//   o_q     : synchronized output (second flop)
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/ain_conditioner.sv
// ain_conditioner: debounces two raw switch lines as one 2-bit vector and
// presents a clean registered code plus a one-cycle change strobe.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : ain_conditioner_if.slave (ain_raw in, ain_out/ain_strobe out)
// Parameter DEBOUNCE_CYCLES (1..255): consecutive identical samples beyond
// the first needed to commit a new code.
// Build option: define AIN_COND_SYNC_EN to put a 2-flop synchronizer in
// front of the FSM (adds 2 cycles of latency); otherwise ain_raw is sampled
// directly and must meet setup to clk.
module ain_conditioner
  import ain_cond_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  ain_conditioner_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       w_s;
  state_t           r_state;
  logic [1:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_out;
  logic             r_stb;

`ifdef AIN_COND_SYNC_EN
  sync2 #(.WIDTH(2)) u_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (bus.ain_raw),
    .o_q     (w_s)
  );
`else
  assign w_s = bus.ain_raw;
`endif

  // Whole vector is debounced as a unit: any deviation from the candidate
  // restarts the count, so a partial code can never be committed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= STABLE;
      r_cand  <= CODE_IDLE;
      r_cnt   <= '0;
      r_out   <= CODE_IDLE;
      r_stb   <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      case (r_state)
        STABLE: begin
          if (w_s != r_out) begin
            r_cand  <= w_s;
            r_cnt   <= CNT_ONE;
            r_state <= CANDIDATE;
          end
        end
        CANDIDATE: begin
          if (w_s == r_out) begin
            // bounced back to the committed code
            r_cnt   <= '0;
            r_state <= STABLE;
          end else if (w_s != r_cand) begin
            r_cand <= w_s;
            r_cnt  <= CNT_ONE;
          end else if (r_cnt == CNT_MAX) begin
            r_out   <= r_cand;
            r_stb   <= 1'b1;
            r_cnt   <= '0;
            r_state <= STABLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_state <= STABLE;
      endcase
    end
  end

  assign bus.ain_out    = r_out;
  assign bus.ain_strobe = r_stb;
endmodule

// File: tb/tb_ain_conditioner.sv
// tb_ain_conditioner: table-driven check of ain_conditioner (DEBOUNCE_CYCLES=4).
// Each vector is applied at the falling edge; outputs are compared 1ns after
// the following rising edge. With AIN_COND_SYNC_EN the clean-change latency
// sequence for the synchronized build is run instead.
module tb_ain_conditioner;

  typedef struct {
    logic [1:0] raw;
    logic       rst_n;
    logic [1:0] exp_out;
    logic       exp_stb;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  ain_conditioner_if bus();

  ain_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input int n, input logic [1:0] raw, input logic rst_n,
                     input logic [1:0] eo, input logic es);
    vec_t v;
    v.raw = raw; v.rst_n = rst_n; v.exp_out = eo; v.exp_stb = es;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic apply_check(input int idx, input vec_t v);
    @(negedge clk);
    reset_n     = v.rst_n;
    bus.ain_raw = v.raw;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ain_out !== v.exp_out || bus.ain_strobe !== v.exp_stb) begin
      errors++;
      $display("FAIL vec%0d: ain_out=%b ain_strobe=%b, required ain_out=%b ain_strobe=%b",
               idx, bus.ain_out, bus.ain_strobe, v.exp_out, v.exp_stb);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.ain_raw = 2'b00;

`ifdef AIN_COND_SYNC_EN
    // reset, settle, then clean 00->11: commit after E0+6
    add(3, 2'b11, 1'b0, 2'b00, 1'b0);
    add(3, 2'b00, 1'b1, 2'b00, 1'b0);
    add(6, 2'b11, 1'b1, 2'b00, 1'b0);
    add(1, 2'b11, 1'b1, 2'b11, 1'b1);
    add(2, 2'b11, 1'b1, 2'b11, 1'b0);
`else
    // reset held with raw=11, then released with raw=00
    add(3, 2'b11, 1'b0, 2'b00, 1'b0);
    add(3, 2'b00, 1'b1, 2'b00, 1'b0);
    // clean change 00->11, commit after E0+4
    add(4, 2'b11, 1'b1, 2'b00, 1'b0);
    add(1, 2'b11, 1'b1, 2'b11, 1'b1);
    add(1, 2'b11, 1'b1, 2'b11, 1'b0);
    // return to 00
    add(4, 2'b00, 1'b1, 2'b11, 1'b0);
    add(1, 2'b00, 1'b1, 2'b00, 1'b1);
    add(1, 2'b00, 1'b1, 2'b00, 1'b0);
    // bounce: 10 x2, 00 x1, 10 x2 -> nothing
    add(2, 2'b10, 1'b1, 2'b00, 1'b0);
    add(1, 2'b00, 1'b1, 2'b00, 1'b0);
    add(2, 2'b10, 1'b1, 2'b00, 1'b0);
    // hold 10 for 5 more: commit on the 3rd (cnt reaches 4)
    add(2, 2'b10, 1'b1, 2'b00, 1'b0);
    add(1, 2'b10, 1'b1, 2'b10, 1'b1);
    add(2, 2'b10, 1'b1, 2'b10, 1'b0);
    // return to 00
    add(4, 2'b00, 1'b1, 2'b10, 1'b0);
    add(1, 2'b00, 1'b1, 2'b00, 1'b1);
    add(1, 2'b00, 1'b1, 2'b00, 1'b0);
    // candidate swap: 01 x3 then 11 -> count restarts, direct 00->11
    add(3, 2'b01, 1'b1, 2'b00, 1'b0);
    add(4, 2'b11, 1'b1, 2'b00, 1'b0);
    add(1, 2'b11, 1'b1, 2'b11, 1'b1);
    add(1, 2'b11, 1'b1, 2'b11, 1'b0);
    // return to 00
    add(4, 2'b00, 1'b1, 2'b11, 1'b0);
    add(1, 2'b00, 1'b1, 2'b00, 1'b1);
    add(1, 2'b00, 1'b1, 2'b00, 1'b0);
    // reset mid-debounce at cnt=3, then full re-debounce to 11
    add(3, 2'b11, 1'b1, 2'b00, 1'b0);
    add(1, 2'b11, 1'b0, 2'b00, 1'b0);
    add(4, 2'b11, 1'b1, 2'b00, 1'b0);
    add(1, 2'b11, 1'b1, 2'b11, 1'b1);
    add(2, 2'b11, 1'b1, 2'b11, 1'b0);
`endif

    for (int i = 0; i < vecs.size(); i++) apply_check(i, vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
